// File: rtl/fact_pkg.sv
// Shared encodings for the factorial accelerator bus initiator.
package fact_pkg;

    typedef enum logic [1:0] {
        FB_IDLE   = 2'd0,
        FB_REQ    = 2'd1,
        FB_RUN    = 2'd2,
        FB_SETTLE = 2'd3
    } fb_state_e;

    localparam logic [1:0] FB_ADDR_N      = 2'd0;
    localparam logic [1:0] FB_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] FB_ADDR_STATUS = 2'd2;
    localparam logic [1:0] FB_ADDR_RESULT = 2'd3;

    localparam int unsigned FB_ST_DONE    = 0;
    localparam int unsigned FB_ST_BUSY    = 1;
    localparam int unsigned FB_ST_ERROR   = 2;
    localparam int unsigned FB_ST_TIMEOUT = 3;
    localparam int unsigned FB_ST_W       = 4;

    // Sticky completion flags, cleared only by an accepted start.
    typedef struct packed {
        logic timeout;
        logic error;
        logic done;
    } fb_flags_t;

endpackage

// File: rtl/fb_timeout_ctr.sv
// Clearable up-counter; tc_c flags the cycle whose increment reaches all-ones.
module fb_timeout_ctr #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam logic [W-1:0] TC_VAL = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == TC_VAL);

endmodule

// File: rtl/fact_bus_if.sv
// Memory-mapped initiator: drives the factorial go/n handshake and latches result/status.
module fact_bus_if
    import fact_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_W    = 4,
    parameter int unsigned TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic [N_W-1:0]    fact_n,
    output logic              fact_go,
    input  logic              fact_done,
    input  logic              fact_error,
    input  logic [DATA_W-1:0] fact_result,
    output logic              irq
);

    fb_state_e         state, state_next;
    fb_flags_t         flags, flags_next;
    logic [DATA_W-1:0] result_reg, result_next;
    logic [N_W-1:0]    n_reg;
    logic              start_c;
    logic              ctr_clr, ctr_en, tc_c;
    logic              busy;

    assign start_c = we && (addr == FB_ADDR_CTRL) && wd[0];
    assign busy    = (state != FB_IDLE);

    fb_timeout_ctr #(.W(TO_W)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .tc_c (tc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, flag and result updates; completion has priority over timeout.
    always_comb begin
        state_next  = state;
        flags_next  = flags;
        result_next = result_reg;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        case (state)
            FB_IDLE: begin
                if (start_c) begin
                    flags_next = '0;
                    ctr_clr    = 1'b1;
                    state_next = FB_REQ;
                end
            end
            FB_REQ: begin
                ctr_en = 1'b1;
                if (fact_done && fact_error) begin
                    flags_next.error = 1'b1;
                    state_next       = FB_IDLE;
                end else if (tc_c) begin
                    flags_next.timeout = 1'b1;
                    state_next         = FB_IDLE;
                end else if (!fact_done) begin
                    state_next = FB_RUN;
                end
            end
            FB_RUN: begin
                ctr_en = 1'b1;
                if (fact_done) begin
                    state_next = FB_SETTLE;
                end else if (tc_c) begin
                    flags_next.timeout = 1'b1;
                    state_next         = FB_IDLE;
                end
            end
            FB_SETTLE: begin
                result_next     = fact_result;
                flags_next.done = 1'b1;
                state_next      = FB_IDLE;
            end
            default: begin
                state_next = FB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags      <= '0;
            result_reg <= '0;
            n_reg      <= '0;
            fact_go    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            flags      <= flags_next;
            result_reg <= result_next;
            fact_go    <= (state_next == FB_REQ) || (state_next == FB_RUN);
            irq        <= flags_next.done | flags_next.error | flags_next.timeout;
            if (we && (addr == FB_ADDR_N) && (state == FB_IDLE)) begin
                n_reg <= wd[N_W-1:0];
            end
        end
    end

    assign fact_n = n_reg;

    // CTRL is write-only with a self-clearing start bit, so it reads as zero.
    always_comb begin
        rd = '0;
        case (addr)
            FB_ADDR_N:      rd = DATA_W'(n_reg);
            FB_ADDR_STATUS: rd = DATA_W'({flags.timeout, flags.error, busy, flags.done});
            FB_ADDR_RESULT: rd = result_reg;
            default:        rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_bus_if.sv
// Self-checking bench for fact_bus_if with a behavioural factorial accelerator model.
module tb_fact_bus_if;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_W    = 4;
    localparam int unsigned TO_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic [1:0]        addr = 2'd0;
    logic [DATA_W-1:0] wd = '0;
    logic [DATA_W-1:0] rd;
    logic [N_W-1:0]    fact_n;
    logic              fact_go;
    logic              fact_done;
    logic              fact_error;
    logic [DATA_W-1:0] fact_result;
    logic              irq;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit hang = 1'b0;

    fact_bus_if #(.DATA_W(DATA_W), .N_W(N_W), .TO_W(TO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .addr        (addr),
        .wd          (wd),
        .rd          (rd),
        .fact_n      (fact_n),
        .fact_go     (fact_go),
        .fact_done   (fact_done),
        .fact_error  (fact_error),
        .fact_result (fact_result),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] fact(input int n);
        logic [DATA_W-1:0] r = 1;
        for (int i = 2; i <= n; i++) r = r * DATA_W'(i);
        return r;
    endfunction

    // Accelerator model: done=1 when idle, drops the cycle after a go rise, rejects n>12.
    logic       m_active, m_go_q;
    logic [2:0] m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fact_done   <= 1'b1;
            fact_error  <= 1'b0;
            fact_result <= '0;
            m_active    <= 1'b0;
            m_go_q      <= 1'b0;
            m_cnt       <= '0;
        end else begin
            m_go_q <= fact_go;
            if (!fact_go) fact_error <= 1'b0;
            if (!m_active) begin
                if (fact_go && !m_go_q) begin
                    if (fact_n > 12) begin
                        fact_error <= 1'b1;
                    end else begin
                        fact_done   <= 1'b0;
                        m_active    <= 1'b1;
                        m_cnt       <= 3'd3;
                        fact_result <= fact(int'(fact_n));
                    end
                end
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 3'd1;
            end else if (!hang) begin
                fact_done <= 1'b1;
                m_active  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [DATA_W-1:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic start_run(input int n, input bit expect_ok);
        bus_wr(2'd0, DATA_W'(n));
        bus_wr(2'd1, 1);
        if (expect_ok) exp_q.push_back(fact(n));
    endtask

    task automatic wait_idle(input string tag);
        logic [DATA_W-1:0] s;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus_rd(2'd2, s);
            if (!s[1]) break;
        end
        chk({tag, "_idle"}, DATA_W'(s[1]), 0);
    endtask

    task automatic pop_result(input string tag);
        logic [DATA_W-1:0] r;
        chk({tag, "_sb_size"}, DATA_W'(exp_q.size()), 1);
        bus_rd(2'd3, r);
        if (exp_q.size() > 0) chk({tag, "_result"}, r, exp_q.pop_front());
    endtask

    logic [DATA_W-1:0] v;
    int go_cycles;

    initial begin
        repeat (2) @(negedge clk);
        bus_rd(2'd2, v); chk("rst_status", v, 0);
        bus_rd(2'd3, v); chk("rst_result", v, 0);
        chk("rst_go", DATA_W'(fact_go), 0);
        chk("rst_irq", DATA_W'(irq), 0);
        chk("rst_n", DATA_W'(fact_n), 0);
        rst = 1'b0;
        @(negedge clk);

        // N=5 normal run
        start_run(5, 1'b1);
        chk("n5_go_rise", DATA_W'(fact_go), 1);
        chk("n5_busy_irq", DATA_W'(irq), 0);
        wait_idle("n5");
        pop_result("n5");
        bus_rd(2'd2, v); chk("n5_status", v, 1);
        chk("n5_irq", DATA_W'(irq), 1);
        chk("n5_go_low", DATA_W'(fact_go), 0);

        // N=13 rejected by accelerator
        start_run(13, 1'b0);
        go_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (fact_go) go_cycles++;
            @(negedge clk);
        end
        chk("n13_go_cycles", DATA_W'(go_cycles), 2);
        bus_rd(2'd2, v); chk("n13_status", v, 4);
        bus_rd(2'd3, v); chk("n13_result_kept", v, 120);
        chk("n13_irq", DATA_W'(irq), 1);

        // Accelerator never completes: timeout after 15 cycles
        hang = 1'b1;
        start_run(2, 1'b0);
        repeat (14) @(negedge clk);
        bus_rd(2'd2, v); chk("to_busy_at_14", v, 2);
        @(negedge clk);
        bus_rd(2'd2, v); chk("to_status", v, 8);
        chk("to_go", DATA_W'(fact_go), 0);
        bus_rd(2'd3, v); chk("to_result_kept", v, 120);
        hang = 1'b0;
        repeat (3) @(negedge clk);

        // Mid-run N write and start are ignored
        start_run(6, 1'b1);
        bus_wr(2'd0, 3);
        bus_wr(2'd1, 1);
        chk("mid_n_held", DATA_W'(fact_n), 6);
        wait_idle("n6");
        pop_result("n6");
        chk("n6_n_after", DATA_W'(fact_n), 6);
        repeat (2) @(negedge clk);
        bus_rd(2'd2, v); chk("n6_no_restart", v, 1);

        // Async reset during RUN
        start_run(7, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_go", DATA_W'(fact_go), 0);
        bus_rd(2'd2, v); chk("rst_mid_status", v, 0);
        bus_rd(2'd3, v); chk("rst_mid_result", v, 0);
        chk("rst_mid_irq", DATA_W'(irq), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_run(0, 1'b1);
        wait_idle("n0");
        pop_result("n0");

        // Back-to-back runs
        start_run(4, 1'b1);
        wait_idle("n4");
        pop_result("n4");
        start_run(1, 1'b1);
        bus_rd(2'd2, v); chk("b2b_status_busy", v, 2);
        bus_rd(2'd3, v); chk("b2b_result_held", v, 24);
        wait_idle("n1");
        pop_result("n1");
        bus_rd(2'd2, v); chk("n1_status", v, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
